// File: rtl/alu_pkg.sv
// Shared single-word ALU types plus the multi-word sequencer state and command helpers.
package alu_pkg;

  typedef logic [15:0] AluVal;

  typedef enum logic [2:0] {ADD, SUB, AND, OR, XOR, XNOR, COMP, RSHFT} AluCmd;

  typedef struct packed {
    AluCmd cmd;
    logic  b_inv;
    logic  carry_in;
    logic  carry_disable;
  } AluCtrl;

  typedef struct packed {
    AluVal  d1;
    AluVal  d2;
    AluCtrl ctrl;
  } AluArgs;

  typedef struct packed {
    AluVal res;
    logic  carry_out;
  } AluRet;

  typedef enum logic [1:0] {IDLE, RUN, DONE} AluMwState;

  function automatic logic is_logic_cmd(AluCmd c);
    return (c == AND) || (c == OR) || (c == XOR) || (c == XNOR);
  endfunction

  // Right shift pulls bits down from the upper word, so it must walk MSW first.
  function automatic logic is_msw_first(AluCmd c);
    return c == RSHFT;
  endfunction

endpackage

// File: rtl/alu_mw_seq_if.sv
// Request/response bundle between the datapath controller and the multi-word ALU sequencer.
interface alu_mw_seq_if #(parameter int WORDS = 4);
  import alu_pkg::*;
  localparam int W = $bits(AluVal);

  logic                 req_valid;
  logic                 req_ready;
  AluCmd                req_cmd;
  logic                 req_b_inv;
  logic                 req_carry_in;
  logic [WORDS*W-1:0]   req_a;
  logic [WORDS*W-1:0]   req_b;
  logic                 resp_valid;
  logic                 resp_ready;
  logic [WORDS*W-1:0]   resp_res;
  logic                 resp_carry_out;
  logic                 resp_zero;
  logic                 resp_all_ones;

  modport master (
    output req_valid, req_cmd, req_b_inv, req_carry_in, req_a, req_b, resp_ready,
    input  req_ready, resp_valid, resp_res, resp_carry_out, resp_zero, resp_all_ones
  );

  modport slave (
    input  req_valid, req_cmd, req_b_inv, req_carry_in, req_a, req_b, resp_ready,
    output req_ready, resp_valid, resp_res, resp_carry_out, resp_zero, resp_all_ones
  );
endinterface

// File: rtl/alu.sv
// Shared combinational single-word ALU; lives outside the sequencer so several users can share it.
module alu
  import alu_pkg::*;
(
  input  AluArgs args,
  output AluRet  ret
);
  localparam int W = $bits(AluVal);

  AluVal      bb;
  logic [W:0] sum;

  always_comb begin
    bb  = args.ctrl.b_inv ? ~args.d2 : args.d2;
    sum = '0;
    ret = '0;
    case (args.ctrl.cmd)
      ADD: begin
        sum = {1'b0, args.d1} + {1'b0, bb} + (W+1)'(args.ctrl.carry_in);
        ret.res = sum[W-1:0];
        ret.carry_out = sum[W];
      end
      SUB: begin
        sum = {1'b0, args.d1} + {1'b0, ~bb} + (W+1)'(args.ctrl.carry_in);
        ret.res = sum[W-1:0];
        ret.carry_out = sum[W];
      end
      AND:  ret.res = args.d1 & bb;
      OR:   ret.res = args.d1 | bb;
      XOR:  ret.res = args.d1 ^ bb;
      XNOR: ret.res = ~(args.d1 ^ bb);
      COMP: ret.res = ~args.d1;
      RSHFT: begin
        ret.res = {args.ctrl.carry_in, bb[W-1:1]};
        ret.carry_out = bb[0];
      end
      default: ret = '0;
    endcase
    // Logic ops pass no carry when disabled, so the chain stays quiet.
    if (is_logic_cmd(args.ctrl.cmd))
      ret.carry_out = args.ctrl.carry_disable ? 1'b0 : args.ctrl.carry_in;
  end
endmodule

// File: rtl/alu_mw_seq.sv
// Multi-word ALU sequencer: feeds one word per cycle to the external ALU, chains the carry,
// assembles the wide result and reports zero / all-ones flags.
module alu_mw_seq
  import alu_pkg::*;
#(
  parameter int WORDS = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  alu_mw_seq_if.slave       bus,
  output AluArgs            alu_args,
  input  AluRet             alu_ret
);
  localparam int W  = $bits(AluVal);
  localparam int IW = $clog2(WORDS);

  typedef logic [WORDS-1:0][W-1:0] wide_t;

  AluMwState       state, state_n;
  AluCmd           cmd_q;
  logic            b_inv_q;
  logic            carry_q;
  wide_t           a_q, b_q, res_q;
  logic [IW-1:0]   idx;
  logic            fire, last, msw;

  assign msw  = is_msw_first(cmd_q);
  assign last = msw ? (idx == '0) : (idx == IW'(WORDS-1));
  assign fire = bus.req_valid && bus.req_ready;

  always_ff @(posedge clk) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_n;
  end

  always_comb begin
    state_n       = state;
    bus.req_ready = 1'b0;
    case (state)
      IDLE: begin
        bus.req_ready = 1'b1;
        if (bus.req_valid) state_n = RUN;
      end
      RUN:     if (last) state_n = DONE;
      DONE:    if (bus.resp_ready) state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cmd_q   <= ADD;
      b_inv_q <= 1'b0;
      carry_q <= 1'b0;
      a_q     <= '0;
      b_q     <= '0;
      res_q   <= '0;
      idx     <= '0;
    end else if (fire) begin
      cmd_q   <= bus.req_cmd;
      b_inv_q <= bus.req_b_inv;
      carry_q <= bus.req_carry_in;
      a_q     <= bus.req_a;
      b_q     <= bus.req_b;
      idx     <= is_msw_first(bus.req_cmd) ? IW'(WORDS-1) : '0;
    end else if (state == RUN) begin
      res_q[idx] <= alu_ret.res;
      // Shift carry is the bit falling out of the word just processed; the ALU's is unused.
      carry_q    <= msw ? b_q[idx][0] : alu_ret.carry_out;
      if (!last) idx <= msw ? idx - 1'b1 : idx + 1'b1;
    end
  end

  always_comb begin
    alu_args = '0;
    if (state == RUN) begin
      alu_args.d1                 = a_q[idx];
      alu_args.d2                 = b_q[idx];
      alu_args.ctrl.cmd           = cmd_q;
      alu_args.ctrl.b_inv         = b_inv_q;
      alu_args.ctrl.carry_in      = carry_q;
      alu_args.ctrl.carry_disable = is_logic_cmd(cmd_q);
    end
  end

  assign bus.resp_valid     = (state == DONE);
  assign bus.resp_res       = res_q;
  assign bus.resp_carry_out = (state == DONE) && carry_q;
  assign bus.resp_zero      = (state == DONE) && (res_q == '0);
  assign bus.resp_all_ones  = (state == DONE) && (&res_q);
endmodule

// File: tb/tb_alu_mw_seq.sv
// Bench for alu_mw_seq with the shared ALU attached: vector table, scoreboard, corner sequences.
module tb_alu_mw_seq;
  import alu_pkg::*;

  localparam int WORDS = 4;
  localparam int NB    = WORDS * 16;

  typedef struct {
    AluCmd         cmd;
    logic          b_inv;
    logic          cin;
    logic [NB-1:0] a;
    logic [NB-1:0] b;
    logic [NB-1:0] res;
    logic          cout;
    logic          zero;
    logic          ones;
  } vec_t;

  typedef struct {
    vec_t v;
    int   fire;
  } sb_t;

  logic   clk = 1'b0;
  logic   rst_n = 1'b0;
  AluArgs alu_args;
  AluRet  alu_ret;
  int     cyc = 0;
  int     n_vec = 0;
  int     n_err = 0;
  logic   in_resp = 1'b0;
  sb_t    sbq[$];
  vec_t   vecs[$];

  alu_mw_seq_if #(.WORDS(WORDS)) bus ();

  alu u_alu (.args(alu_args), .ret(alu_ret));

  alu_mw_seq #(.WORDS(WORDS)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .bus      (bus),
    .alu_args (alu_args),
    .alu_ret  (alu_ret)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [NB-1:0] act, input logic [NB-1:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic vec_t mk(AluCmd c, logic bi, logic ci, logic [NB-1:0] a, logic [NB-1:0] b,
                              logic [NB-1:0] res, logic co);
    vec_t v;
    v.cmd = c; v.b_inv = bi; v.cin = ci; v.a = a; v.b = b;
    v.res = res; v.cout = co; v.zero = (res == '0); v.ones = (&res);
    return v;
  endfunction

  // Wide reference for bitwise commands; no carry ever leaves the top word.
  function automatic vec_t mk_logic(AluCmd c, logic bi, logic ci, logic [NB-1:0] a, logic [NB-1:0] b);
    logic [NB-1:0] bb, r;
    bb = bi ? ~b : b;
    case (c)
      AND:     r = a & bb;
      OR:      r = a | bb;
      XOR:     r = a ^ bb;
      default: r = ~(a ^ bb);
    endcase
    return mk(c, bi, ci, a, b, r, 1'b0);
  endfunction

  // Scoreboard side: latency on first sight of resp_valid, contents on handshake.
  always @(negedge clk) begin
    if (!rst_n) begin
      in_resp = 1'b0;
    end else begin
      if (bus.resp_valid && !in_resp) begin
        in_resp = 1'b1;
        if (sbq.size() == 0) chk("unexpected_resp", 1, 0);
        else                 chk("latency", NB'(cyc - sbq[0].fire), NB'(WORDS));
      end
      if (bus.resp_valid && bus.resp_ready && sbq.size() != 0) begin
        sb_t e;
        e = sbq.pop_front();
        chk("res",      bus.resp_res,       e.v.res);
        chk("cout",     bus.resp_carry_out, e.v.cout);
        chk("zero",     bus.resp_zero,      e.v.zero);
        chk("all_ones", bus.resp_all_ones,  e.v.ones);
        in_resp = 1'b0;
      end
    end
  end

  task automatic send(input vec_t v);
    sb_t e;
    @(negedge clk);
    bus.req_cmd      = v.cmd;
    bus.req_b_inv    = v.b_inv;
    bus.req_carry_in = v.cin;
    bus.req_a        = v.a;
    bus.req_b        = v.b;
    bus.req_valid    = 1'b1;
    for (int k = 0; k < 50 && !bus.req_ready; k++) @(negedge clk);
    if (!bus.req_ready) begin
      chk("req_ready_timeout", 0, 1);
    end else begin
      e.v = v; e.fire = cyc + 1;
      sbq.push_back(e);
    end
    @(posedge clk);
    #1;
    bus.req_valid = 1'b0;
    bus.req_a     = {$urandom, $urandom};
    bus.req_b     = {$urandom, $urandom};
    bus.req_cmd   = COMP;
  endtask

  task automatic drain();
    for (int k = 0; k < 100 && sbq.size() != 0; k++) @(negedge clk);
    if (sbq.size() != 0) begin
      chk("resp_timeout", 0, 1);
      sbq.delete();
    end
  endtask

  initial begin
    bus.req_valid = 1'b0; bus.req_cmd = ADD; bus.req_b_inv = 1'b0; bus.req_carry_in = 1'b0;
    bus.req_a = '0; bus.req_b = '0; bus.resp_ready = 1'b1;

    vecs.push_back(mk(ADD, 0, 0, 64'h0000_0000_0000_FFFF, 64'h1, 64'h0000_0000_0001_0000, 0));
    vecs.push_back(mk(ADD, 0, 0, 64'hFFFF_FFFF_FFFF_FFFF, 64'h1, 64'h0, 1));
    vecs.push_back(mk(ADD, 1, 1, 64'h5, 64'h7, 64'hFFFF_FFFF_FFFF_FFFE, 0));
    vecs.push_back(mk(ADD, 1, 0, 64'h7, 64'h7, 64'hFFFF_FFFF_FFFF_FFFF, 0));
    vecs.push_back(mk(ADD, 0, 0, 64'h0000_FFFF_FFFF_FFFF, 64'h1, 64'h0001_0000_0000_0000, 0));
    vecs.push_back(mk(SUB, 0, 1, 64'hA, 64'h3, 64'h7, 1));
    vecs.push_back(mk(RSHFT, 0, 0, 64'h0, 64'h8000_0000_0000_0002, 64'h4000_0000_0000_0001, 0));
    for (int i = 0; i < 6; i++) begin
      AluCmd c;
      case ($urandom_range(0, 2))
        0:       c = AND;
        1:       c = OR;
        default: c = XOR;
      endcase
      vecs.push_back(mk_logic(c, 1'($urandom), 1'($urandom), {$urandom, $urandom}, {$urandom, $urandom}));
    end

    // Reset state
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_resp_valid", bus.resp_valid, 0);
    chk("rst_resp_res",   bus.resp_res, 0);
    chk("rst_flags",      {bus.resp_carry_out, bus.resp_zero, bus.resp_all_ones}, 0);
    chk("rst_alu_args",   alu_args, 0);
    chk("rst_req_ready",  bus.req_ready, 1);
    rst_n = 1'b1;

    foreach (vecs[i]) begin
      send(vecs[i]);
      drain();
    end

    // RSHFT walks MSW first and forwards the dropped bit as the next carry
    send(mk(RSHFT, 0, 1, 64'h1234, 64'h0001_0000_0000_0001, 64'h8000_8000_0000_0000, 1));
    @(negedge clk);
    chk("rshft_w0_d2",  alu_args.d2, 16'h0001);
    chk("rshft_w0_cin", alu_args.ctrl.carry_in, 1);
    @(negedge clk);
    chk("rshft_w1_d2",  alu_args.d2, 16'h0000);
    chk("rshft_w1_cin", alu_args.ctrl.carry_in, 1);
    drain();

    // Backpressure: result held, new requests refused
    bus.resp_ready = 1'b0;
    send(mk(ADD, 0, 0, 64'h0000_0000_0000_FFFF, 64'h1, 64'h0000_0000_0001_0000, 0));
    for (int k = 0; k < 20 && !bus.resp_valid; k++) @(negedge clk);
    for (int k = 0; k < 3; k++) begin
      chk("bp_resp_valid", bus.resp_valid, 1);
      chk("bp_resp_res",   bus.resp_res, 64'h0000_0000_0001_0000);
      chk("bp_req_ready",  bus.req_ready, 0);
      bus.req_valid = 1'b1;
      bus.req_a     = {$urandom, $urandom};
      @(negedge clk);
    end
    @(posedge clk);
    #1;
    bus.req_valid  = 1'b0;
    bus.resp_ready = 1'b1;
    drain();
    @(negedge clk);
    chk("bp_valid_drop", bus.resp_valid, 0);
    chk("bp_idle_ready", bus.req_ready, 1);
    repeat (6) @(negedge clk);
    chk("bp_no_extra", bus.resp_valid, 0);

    // Reset while word 2 is in flight
    send(mk(ADD, 0, 0, 64'hFFFF_FFFF_FFFF_FFFF, 64'h1, 64'h0, 1));
    @(posedge clk);
    @(posedge clk);
    #1;
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    sbq.delete();
    @(negedge clk);
    chk("abort_resp_valid", bus.resp_valid, 0);
    chk("abort_req_ready",  bus.req_ready, 1);
    chk("abort_alu_args",   alu_args, 0);
    send(mk_logic(XOR, 0, 1, 64'h0123_4567_89AB_CDEF, 64'hFFFF_0000_FFFF_0000));
    @(negedge clk);
    chk("xor_carry_disable", alu_args.ctrl.carry_disable, 1);
    chk("xor_w0_d1",         alu_args.d1, 16'hCDEF);
    drain();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1);
  end
endmodule
